// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
// Holds the limb width, the sequencer state encoding and the counter width helper.
// Pure declarations: no logic, no latency, no flow control.
package mp_add_pkg;

  localparam int LIMB_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Limb counter width; LIMBS is at least 2, so this is never zero.
  function automatic int limb_cnt_w(input int limbs);
    return (limbs <= 2) ? 1 : $clog2(limbs);
  endfunction

endpackage

// File: rtl/carry_bypass_adder.sv
// Combinational W-bit carry-bypass adder: ripple inside BLK-bit blocks, skip mux per block.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the caller owns all flow control.
module carry_bypass_adder #(
  parameter int W   = 32,
  parameter int BLK = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);

  localparam int NBLK = W / BLK;

  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Carry chain: ripple within each block; when every bit of a block propagates,
  // the block carry-out is taken straight from the block carry-in.
  always_comb begin
    logic [W:0] cv;
    cv    = '0;
    cv[0] = c_in;
    for (int k = 0; k < NBLK; k++) begin
      for (int j = 0; j < BLK; j++) begin
        cv[k*BLK+j+1] = g[k*BLK+j] | (p[k*BLK+j] & cv[k*BLK+j]);
      end
      if (&p[k*BLK +: BLK]) begin
        cv[(k+1)*BLK] = cv[k*BLK];
      end
    end
    c = cv;
  end

  assign sum   = p ^ c[W-1:0];
  assign c_out = c[W];

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision A+B / A-B, one 32-bit limb per cycle (LSB first) through a shared adder.
// Latency: each result limb is valid one cycle after its input handshake; done one cycle after the last output transfer.
// Backpressure: out_valid && !out_ready holds the output register and drops in_ready. Optional flags: MPADD_FLAGS_EN.
module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter int LIMBS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_sub,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LIMB_W-1:0] a_limb,
  input  logic [LIMB_W-1:0] b_limb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIMB_W-1:0] sum_limb,
  output logic              out_last,
  output logic              carry_final,
  output logic              busy,
  output logic              done
`ifdef MPADD_FLAGS_EN
  ,
  output logic              zero_flag,
  output logic              ovf_flag
`endif
);

  localparam int CW = limb_cnt_w(LIMBS);

  state_t            state;
  state_t            state_nxt;
  logic              op_sub_q;
  logic              carry_q;
  logic [CW-1:0]     cnt;
  logic              last_limb;
  logic              in_hs;
  logic              out_hs;
  logic [LIMB_W-1:0] b_eff;
  logic [LIMB_W-1:0] add_sum;
  logic              add_cout;

  assign last_limb = (cnt == CW'(LIMBS - 1));
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign busy      = (state != IDLE);

  // Subtraction is A + ~B + 1; the +1 comes from the carry register seeded with op_sub.
  assign b_eff = op_sub_q ? ~b_limb : b_limb;

  carry_bypass_adder #(
    .W   (LIMB_W),
    .BLK (4)
  ) u_adder (
    .a     (a_limb),
    .b     (b_eff),
    .c_in  (carry_q),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and input-side flow control.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && (!out_valid || out_ready) && last_limb) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (out_hs) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: operation capture, carry chaining between limbs, output register, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_sub_q    <= 1'b0;
      carry_q     <= 1'b0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      sum_limb    <= '0;
      out_last    <= 1'b0;
      carry_final <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_sub_q <= op_sub;
            carry_q  <= op_sub;
            cnt      <= '0;
          end
        end
        RUN: begin
          if (out_hs) begin
            out_valid <= 1'b0;
          end
          if (in_hs) begin
            out_valid <= 1'b1;
            sum_limb  <= add_sum;
            carry_q   <= add_cout;
            out_last  <= last_limb;
            cnt       <= last_limb ? '0 : cnt + CW'(1);
            if (last_limb) begin
              carry_final <= add_cout;
            end
          end
        end
        FLUSH: begin
          if (out_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MPADD_FLAGS_EN
  // Carry into bit 31 is recovered from the sum bit and the two adder operand bits.
  logic msb_carry_in;
  assign msb_carry_in = add_sum[LIMB_W-1] ^ a_limb[LIMB_W-1] ^ b_eff[LIMB_W-1];

  // Per-limb accumulation of the all-zero test; signed overflow captured on the top limb.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_flag <= 1'b0;
      ovf_flag  <= 1'b0;
    end else if (in_hs) begin
      zero_flag <= (add_sum == '0) && ((cnt == '0) || zero_flag);
      if (last_limb) begin
        ovf_flag <= msb_carry_in ^ add_cout;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed bench for mp_add_sequencer with LIMBS=4 and hand-computed results.
// Inputs are driven 2 time units after the rising edge, outputs sampled shortly after.
// Covers reset, add/subtract, overflow, back-pressure, abort by reset and start during RUN.
module tb_mp_add_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op_sub;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_limb;
  logic [31:0] b_limb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum_limb;
  logic        out_last;
  logic        carry_final;
  logic        busy;
  logic        done;
`ifdef MPADD_FLAGS_EN
  logic        zero_flag;
  logic        ovf_flag;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mp_add_sequencer #(.LIMBS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op_sub      (op_sub),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_limb      (a_limb),
    .b_limb      (b_limb),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum_limb    (sum_limb),
    .out_last    (out_last),
    .carry_final (carry_final),
    .busy        (busy),
    .done        (done)
`ifdef MPADD_FLAGS_EN
    ,
    .zero_flag   (zero_flag),
    .ovf_flag    (ovf_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Runs one 4-limb operation. stall: cycles of out_ready=0 after limb 0.
  // poke: limb index during whose handshake start is re-asserted with the opposite op (-1 = never).
  task automatic do_op(input string nm, input logic op, input logic [127:0] a, input logic [127:0] b,
                       input logic [127:0] ex, input logic exc, input logic ezf, input logic eov,
                       input int stall, input int poke);
    start  = 1'b1;
    op_sub = op;
    tick();
    start  = 1'b0;
    chk({nm, " busy"}, {31'b0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a_limb   = a[32*i +: 32];
      b_limb   = b[32*i +: 32];
      if (i == poke) begin
        start  = 1'b1;
        op_sub = ~op;
      end
      #1;
      chk($sformatf("%s in_ready%0d", nm, i), {31'b0, in_ready}, 32'd1);
      tick();
      start  = 1'b0;
      op_sub = op;
      chk($sformatf("%s out_valid%0d", nm, i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("%s limb%0d", nm, i), sum_limb, ex[32*i +: 32]);
      chk($sformatf("%s last%0d", nm, i), {31'b0, out_last}, {31'b0, (i == 3)});
      if (i == 0 && stall > 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          #1;
          chk($sformatf("%s stall_rdy%0d", nm, s), {31'b0, in_ready}, 32'd0);
          chk($sformatf("%s stall_vld%0d", nm, s), {31'b0, out_valid}, 32'd1);
          chk($sformatf("%s stall_limb%0d", nm, s), sum_limb, ex[31:0]);
          tick();
        end
        out_ready = 1'b1;
      end
    end
    in_valid = 1'b0;
    chk({nm, " carry_final"}, {31'b0, carry_final}, {31'b0, exc});
`ifdef MPADD_FLAGS_EN
    chk({nm, " zero_flag"}, {31'b0, zero_flag}, {31'b0, ezf});
    chk({nm, " ovf_flag"}, {31'b0, ovf_flag}, {31'b0, eov});
`else
    if (ezf === 1'bx || eov === 1'bx) $display("note: unknown flag expectation in %s", nm);
`endif
    tick();
    chk({nm, " done"}, {31'b0, done}, 32'd1);
    chk({nm, " idle"}, {31'b0, busy}, 32'd0);
    chk({nm, " drained"}, {31'b0, out_valid}, 32'd0);
    tick();
    chk({nm, " done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    op_sub    = 1'b0;
    in_valid  = 1'b0;
    a_limb    = '0;
    b_limb    = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst sum_limb", sum_limb, 32'd0);
    chk("rst out_last", {31'b0, out_last}, 32'd0);
    chk("rst carry_final", {31'b0, carry_final}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    tick();

    // 0xFFFFFFFF + 1: carry ripples into limb 1 only.
    do_op("add1", 1'b0, 128'h00000000_00000000_00000000_FFFFFFFF, 128'h1,
          128'h00000000_00000000_00000001_00000000, 1'b0, 1'b0, 1'b0, 0, -1);
    // All-ones + 1 wraps to zero with carry out, no signed overflow.
    do_op("addwrap", 1'b0, {128{1'b1}}, 128'h1, 128'h0, 1'b1, 1'b1, 1'b0, 0, -1);
    // 5 - 7 = -2: borrow, so carry_final = 0.
    do_op("sub", 1'b1, 128'h5, 128'h7,
          128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b0, 1'b0, 1'b0, 0, -1);
    // Max positive + 1: signed overflow, no carry out.
    do_op("ovf", 1'b0, 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1,
          128'h80000000_00000000_00000000_00000000, 1'b0, 1'b0, 1'b1, 0, -1);
    // Back-pressure for 3 cycles after limb 0.
    do_op("bp", 1'b0, 128'h00000003_00000002_00000001_FFFFFFFF,
          128'h00000001_00000001_00000001_00000001,
          128'h00000004_00000003_00000003_00000000, 1'b0, 1'b0, 1'b0, 3, -1);
    // start with op_sub=1 during limb 1 must be ignored: result stays the add.
    do_op("poke", 1'b0, 128'h00000000_00000000_00000000_FFFFFFFF, 128'h1,
          128'h00000000_00000000_00000001_00000000, 1'b0, 1'b0, 1'b0, 0, 1);

    // Abort after 2 of 4 limbs.
    start  = 1'b1;
    op_sub = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a_limb   = 32'hFFFFFFFF;
      b_limb   = 32'h1;
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort done", {31'b0, done}, 32'd0);
    chk("abort in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("abort done_late", {31'b0, done}, 32'd0);
    do_op("fresh", 1'b0, 128'h00000000_00000000_00000000_FFFFFFFF, 128'h1,
          128'h00000000_00000000_00000001_00000000, 1'b0, 1'b0, 1'b0, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mp_add_sequencer.md
Name: mp_add_sequencer

Overview:
- Multi-precision add/subtract sequencer around one shared 32-bit carry_bypass_adder instance.
- Accepts LIMBS 32-bit operand limbs per operation, least significant first, over a valid/ready stream.
- Issues one limb per cycle through the adder and chains the carry through a register between limbs.
- Streams result limbs out through a one-deep output register with valid/ready and a last marker.

Parameters:
- LIMBS, 4, limbs per operation (operand width = 32*LIMBS); legal range 2..256.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin operation; sampled only in IDLE.
- op_sub  input  1  0 = A+B, 1 = A-B; captured with start.
- in_valid  input  1  operand limb valid.
- in_ready  output  1  sequencer can take a limb this cycle.
- a_limb  input  32  operand A limb.
- b_limb  input  32  operand B limb.
- out_valid  output  1  result limb valid.
- out_ready  input  1  downstream accepts the result limb.
- sum_limb  output  32  result limb.
- out_last  output  1  marks the final limb of the operation.
- carry_final  output  1  adder carry out of the top limb; valid with out_last (for subtract, 1 = no borrow).
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse after the last limb is transferred out.

Behaviour:
- Reset: state IDLE, limb counter 0, carry register 0, output register 0 (out_valid, sum_limb, out_last, carry_final all 0), in_ready 0, done 0.
- States: IDLE, RUN, FLUSH.
- IDLE: start=1 latches op_sub, loads carry register with op_sub, clears the counter, and moves to RUN next cycle. start=0 or start in any other state is ignored.
- RUN:
  - in_ready = !out_valid || out_ready.
  - The adder computes a_limb + (op_sub ? ~b_limb : b_limb) + carry register.
  - On an input handshake: sum and c_out load into the output register; the carry register takes c_out; out_valid=1; the counter increments.
  - On the limb where counter == LIMBS-1: set out_last=1, load carry_final, go to FLUSH.
- FLUSH: in_ready=0. When out_valid && out_ready, clear out_valid and out_last, go to IDLE, and pulse done that same cycle.
- Latency: each result limb appears one cycle after its input handshake. Full throughput is one limb per cycle when out_ready is held high.
- Back-pressure: out_valid=1 with out_ready=0 holds the output register and forces in_ready=0. Output and input transfers in the same cycle are legal, so there is no bubble.
- Output register holds its value while out_valid && !out_ready; sum_limb is don't-care when out_valid=0.
- Counter width is clog2(LIMBS); it wraps cleanly back to 0 on return to IDLE.
- rst at any time aborts the operation with no done pulse; partial results are discarded.
- busy = (state != IDLE).

Optional Feature:
- Macro MPADD_FLAGS_EN.
- Defined:
  - adds output port zero_flag (1 bit), valid with out_last: 1 iff every result limb of the operation was 0 (accumulated AND of limb-zero tests).
  - adds output port ovf_flag (1 bit), valid with out_last: two's-complement signed overflow of the full-width operation, computed as carry-into-MSB XOR carry-out-of-MSB on the top limb.
  - both flags reset to 0.
- Undefined: neither port exists and no accumulation logic is built.

Decomposition:
- Shared package mp_add_pkg:
  - LIMB_W = 32.
  - state enum {IDLE, RUN, FLUSH}.
  - function limb_cnt_w(LIMBS) = clog2.
- Sub-module: the existing carry_bypass_adder, instantiated once. The B-inversion mux and carry register stay in this block.

Test Plan:
- Add, LIMBS=4, A = 0x00000000_00000000_00000000_FFFFFFFF, B = 1, out_ready=1 → limbs 0x00000000, 0x00000001, 0x00000000, 0x00000000; out_last on the 4th; carry_final=0; done one cycle after the 4th transfer.
- Add, A = all-ones 128-bit, B = 1 → all four limbs 0x00000000; carry_final=1; with MPADD_FLAGS_EN, zero_flag=1 and ovf_flag=0.
- Subtract, A = 5, B = 7 (128-bit) → limb0 0xFFFFFFFE, limbs 1–3 0xFFFFFFFF; carry_final=0 (borrow).
- Back-pressure: out_ready=0 for 3 cycles after the first limb → in_ready=0 and sum_limb stable throughout; the sequence completes correctly after release, with no lost or duplicated limb.
- rst asserted after 2 of 4 limbs → next cycle busy=0, out_valid=0, no done pulse; a following start gives a correct fresh result.
- start asserted during RUN → ignored; op_sub and the limb count are unchanged.
